// File: rtl/aabb_step_sequencer_if.sv
// Control/handshake bundle between the control register unit, the AABB traversal unit
// and aabb_step_sequencer. The sequencer uses the slave modport.
interface aabb_step_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic [WORD_W-1:0] iControlRegister;
  logic              iStepAABB;
  logic [CNT_W-1:0]  iBreakpoint;
  logic              iAABBAck;
  logic              iAABBDone;
  logic              oAABBStart;
  logic [CNT_W-1:0]  oIterCount;
  logic              oBreakHit;
  logic              oHalted;
  logic              oTimeout;

  modport master (
    output iControlRegister, iStepAABB, iBreakpoint, iAABBAck, iAABBDone,
    input  oAABBStart, oIterCount, oBreakHit, oHalted, oTimeout
  );

  modport slave (
    input  iControlRegister, iStepAABB, iBreakpoint, iAABBAck, iAABBDone,
    output oAABBStart, oIterCount, oBreakHit, oHalted, oTimeout
  );
endinterface

// File: rtl/aabb_step_sequencer.sv
// Turns run/step/breakpoint commands into the AABB start/ack/done handshake and counts iterations.
// Optional WAIT watchdog is compiled in when AABB_STEP_TIMEOUT_EN is defined.
module aabb_step_sequencer #(
  parameter int WORD_W         = 32,
  parameter int CNT_W          = 16,
  parameter int RUN_BIT        = 0,
  parameter int STEPMODE_BIT   = 1,
  parameter int BRK_EN_BIT     = 2,
  parameter int CLR_BIT        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 iClock,
  input  logic                 iReset,
  aabb_step_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  state_t           state;
  logic             step_pending;
  logic [CNT_W-1:0] count;
  logic             brk_hit;
  logic             run, step_mode, brk_en, clr, ack, done, step_req;
  logic [CNT_W:0]   count_inc;
  logic             brk_match;
  logic             unused_ctrl;

  assign run         = bus.iControlRegister[RUN_BIT];
  assign step_mode   = bus.iControlRegister[STEPMODE_BIT];
  assign brk_en      = bus.iControlRegister[BRK_EN_BIT];
  assign clr         = bus.iControlRegister[CLR_BIT];
  assign unused_ctrl = ^bus.iControlRegister;
  assign ack         = bus.iAABBAck;
  assign done        = bus.iAABBDone;
  assign step_req    = bus.iStepAABB & step_mode;

  // Compare on the unsaturated count+1 so a saturated counter can never re-hit a breakpoint.
  assign count_inc = {1'b0, count} + (CNT_W + 1)'(1);
  assign brk_match = brk_en && (count_inc == {1'b0, bus.iBreakpoint});

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef AABB_STEP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            timeout;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state        <= IDLE;
      step_pending <= 1'b0;
      count        <= '0;
      brk_hit      <= 1'b0;
`ifdef AABB_STEP_TIMEOUT_EN
      wd           <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      if (clr)
        count <= '0;
      else if ((state == WAIT && done) || (state == ISSUE && ack && done))
        count <= sat_inc(count);

      if (step_req && state != IDLE)
        step_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (step_mode) begin
            if (step_req || step_pending) begin
              state        <= ISSUE;
              step_pending <= 1'b0;
            end
          end else if (run) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Ack+done together returns through IDLE so a free-run reissue keeps its gap cycle.
          if (ack && done) begin
            if (brk_match) begin
              state   <= HALT;
              brk_hit <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (ack) begin
            state <= WAIT;
`ifdef AABB_STEP_TIMEOUT_EN
            wd    <= '0;
`endif
          end
        end
        WAIT: begin
          if (done) begin
            if (brk_match) begin
              state   <= HALT;
              brk_hit <= 1'b1;
            end else if (step_mode) begin
              state <= IDLE;
            end else if (run) begin
              state <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
`ifdef AABB_STEP_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state   <= HALT;
            timeout <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        HALT: begin
          if (!run && !step_mode) begin
            state   <= IDLE;
            brk_hit <= 1'b0;
`ifdef AABB_STEP_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oAABBStart = (state == ISSUE);
  assign bus.oHalted    = (state == HALT);
  assign bus.oIterCount = count;
  assign bus.oBreakHit  = brk_hit;
`ifdef AABB_STEP_TIMEOUT_EN
  assign bus.oTimeout   = timeout;
`else
  assign bus.oTimeout   = 1'b0;
`endif
endmodule

// File: tb/tb_aabb_step_sequencer.sv
// Bench for aabb_step_sequencer: cycle vector table, AABB responder model with count scoreboard.
module tb_aabb_step_sequencer;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aabb_step_sequencer_if #(.WORD_W(32), .CNT_W(CNT_W)) bus ();

  aabb_step_sequencer #(.WORD_W(32), .CNT_W(CNT_W), .TIMEOUT_CYCLES(8)) dut (
    .iClock (clk),
    .iReset (rst_n),
    .bus    (bus.slave)
  );

  logic man_ack   = 1'b0;
  logic man_done  = 1'b0;
  logic auto_ack  = 1'b0;
  logic auto_done = 1'b0;
  logic auto_en   = 1'b0;
  logic hs_abort  = 1'b0;
  logic chk_d;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_done = 0;
  logic [CNT_W-1:0] model_cnt = '0;
  logic [CNT_W-1:0] sb_q[$];

  assign bus.iAABBAck  = man_ack | auto_ack;
  assign bus.iAABBDone = man_done | auto_done;

  typedef struct {
    logic [3:0]       ctrl;
    logic             step;
    logic             ack;
    logic             done;
    logic             exp_start;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[35];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  // AABB unit model: ack one cycle after start, done a few cycles later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_en && bus.oAABBStart && rst_n) begin
        hs_abort = 1'b0;
        auto_ack = 1'b1;
        @(posedge clk);
        #1;
        auto_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (!hs_abort) begin
          if (model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + 1'b1;
          sb_q.push_back(model_cnt);
          auto_done = 1'b1;
          @(posedge clk);
          #1;
          auto_done = 1'b0;
          n_done++;
        end
      end
    end
  end

  always @(posedge clk) begin
    chk_d = auto_done;
    #2;
    if (chk_d) begin
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("sb_iter_count", 32'(bus.oIterCount), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL sim_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int base;
    tbl = '{
      '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}, '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1},
      '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1}, '{4'h2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2}, '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2},
      '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2}, '{4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}, '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0},
      '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0}, '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0},
      '{4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}, '{4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0},
      '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1},
      '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1}, '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2}, '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2},
      '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2}, '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2},
      '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2}, '{4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2},
      '{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2}, '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3},
      '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3}
    };

    rst_n = 1'b0;
    bus.iControlRegister = '0;
    bus.iStepAABB = 1'b0;
    bus.iBreakpoint = '0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_start",   32'(bus.oAABBStart), 0);
    check("rst_count",   32'(bus.oIterCount), 0);
    check("rst_brk",     32'(bus.oBreakHit),  0);
    check("rst_halted",  32'(bus.oHalted),    0);
    check("rst_timeout", 32'(bus.oTimeout),   0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 35; i++) begin
      bus.iControlRegister = {28'd0, tbl[i].ctrl};
      bus.iStepAABB = tbl[i].step;
      man_ack  = tbl[i].ack;
      man_done = tbl[i].done;
      cyc();
      check($sformatf("vec%0d_start", i),  32'(bus.oAABBStart), 32'(tbl[i].exp_start));
      check($sformatf("vec%0d_count", i),  32'(bus.oIterCount), 32'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_halted", i), 32'(bus.oHalted),    0);
    end
    bus.iStepAABB = 1'b0;
    man_ack = 1'b0;
    man_done = 1'b0;

    // Free run, then drop RUN while an iteration is in flight.
    bus.iControlRegister = 32'h8;
    cyc();
    check("clr_count", 32'(bus.oIterCount), 0);
    model_cnt = '0;
    bus.iControlRegister = 32'h1;
    auto_en = 1'b1;
    for (int i = 0; i < 500 && n_done < 10; i++) cyc();
    check("run10_count", 32'(bus.oIterCount), 10);
    for (int i = 0; i < 50 && !auto_ack; i++) cyc();
    check("run11_ack_seen", 32'(auto_ack), 1);
    cyc();
    bus.iControlRegister = 32'h0;
    for (int i = 0; i < 50 && n_done < 11; i++) cyc();
    repeat (4) cyc();
    check("run_stop_count", 32'(bus.oIterCount), 11);
    check("run_stop_start", 32'(bus.oAABBStart), 0);

    // Breakpoint halt at 5.
    bus.iControlRegister = 32'h8;
    cyc();
    model_cnt = '0;
    bus.iBreakpoint = 4'd5;
    bus.iControlRegister = 32'h5;
    for (int i = 0; i < 500 && !bus.oHalted; i++) cyc();
    repeat (3) cyc();
    check("bp_halted", 32'(bus.oHalted),    1);
    check("bp_brkhit", 32'(bus.oBreakHit),  1);
    check("bp_count",  32'(bus.oIterCount), 5);
    check("bp_start",  32'(bus.oAABBStart), 0);
    bus.iControlRegister = 32'h0;
    cyc();
    check("bp_exit_halted", 32'(bus.oHalted),   0);
    check("bp_exit_brkhit", 32'(bus.oBreakHit), 0);

    // Saturation over 20 free-run iterations.
    bus.iControlRegister = 32'h8;
    cyc();
    model_cnt = '0;
    bus.iControlRegister = 32'h1;
    base = n_done;
    for (int i = 0; i < 1000 && n_done < base + 20; i++) cyc();
    check("sat_done_count", n_done - base, 20);
    check("sat_count", 32'(bus.oIterCount), 15);

    // Asynchronous reset while a start request is up.
    for (int i = 0; i < 50 && !bus.oAABBStart; i++) cyc();
    check("rst_issue_seen", 32'(bus.oAABBStart), 1);
    #2;
    rst_n = 1'b0;
    hs_abort = 1'b1;
    #1;
    check("arst_start",  32'(bus.oAABBStart), 0);
    check("arst_count",  32'(bus.oIterCount), 0);
    check("arst_halted", 32'(bus.oHalted),    0);
    check("arst_brk",    32'(bus.oBreakHit),  0);
    auto_en = 1'b0;
    bus.iControlRegister = 32'h0;
    cyc();
    rst_n = 1'b1;
    model_cnt = '0;
    repeat (6) cyc();
    check("post_rst_start", 32'(bus.oAABBStart), 0);
    check("post_rst_count", 32'(bus.oIterCount), 0);

`ifdef AABB_STEP_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      bus.iControlRegister = 32'h2;
      bus.iStepAABB = 1'b1;
      cyc();
      bus.iStepAABB = 1'b0;
      man_ack = 1'b1;
      cyc();
      man_ack = 1'b0;
      repeat (7) cyc();
      check($sformatf("to%0d_pre_halted", k), 32'(bus.oHalted), 0);
      man_done = (k == 1);
      cyc();
      man_done = 1'b0;
      check($sformatf("to%0d_halted", k),  32'(bus.oHalted),  (k == 0) ? 1 : 0);
      check($sformatf("to%0d_timeout", k), 32'(bus.oTimeout), (k == 0) ? 1 : 0);
      check($sformatf("to%0d_count", k),   32'(bus.oIterCount), k);
      bus.iControlRegister = 32'h0;
      cyc();
      check($sformatf("to%0d_exit_timeout", k), 32'(bus.oTimeout), 0);
    end
`else
    check("no_wd_timeout", 32'(bus.oTimeout), 0);
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/aabb_step_sequencer.md
Name: aabb_step_sequencer

Overview:
- Sits directly downstream of the control register unit, which supplies the control register word and the one-cycle step-AABB pulse.
- Converts run/step/breakpoint commands into a start/ack/done handshake with the AABB traversal unit.
- Counts completed AABB iterations and halts the unit on a breakpoint match.
- Its status outputs feed the host status register.

Parameters:
WORD_W, 32, width of the control register word (equals GPU word)
CNT_W, 16, width of the iteration counter and breakpoint
RUN_BIT, 0, control bit: free-run enable
STEPMODE_BIT, 1, control bit: single-step mode (overrides RUN_BIT)
BRK_EN_BIT, 2, control bit: breakpoint compare enable
CLR_BIT, 3, control bit: clear iteration counter
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
iClock  in  1  clock, all logic on rising edge
iReset  in  1  asynchronous, active-low reset (0 = reset)
iControlRegister  in  WORD_W  control word from the control register unit
iStepAABB  in  1  one-cycle step pulse from the control register unit
iBreakpoint  in  CNT_W  iteration count at which to halt
iAABBAck  in  1  AABB unit accepted start
iAABBDone  in  1  AABB unit finished one iteration (1-cycle pulse)
oAABBStart  out  1  start request, held until ack
oIterCount  out  CNT_W  completed iterations, saturating
oBreakHit  out  1  sticky, set on breakpoint halt
oHalted  out  1  1 while in HALT
oTimeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset is asynchronous: iReset=0 forces state IDLE and clears every output and the step-pending flag. Reset mid-handshake drops the request with no recovery action.
- State machine:
  - States: IDLE, ISSUE, WAIT, HALT.
  - All outputs are registered or decoded from state. oAABBStart=1 only in ISSUE. oHalted=1 only in HALT.
- IDLE transitions:
  - STEPMODE=1: go to ISSUE if iStepAABB=1 or stepPending=1, and clear stepPending.
  - STEPMODE=0 and RUN=1: go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE transitions:
  - Hold oAABBStart until iAABBAck=1 is sampled, then go to WAIT.
  - If iAABBAck and iAABBDone are both 1 in the same cycle, treat it as ack followed by immediate completion; apply the WAIT completion rules in that cycle.
- WAIT transitions: on iAABBDone=1:
  - Increment the counter.
  - If BRK_EN=1 and (count+1)==iBreakpoint, go to HALT and set oBreakHit.
  - Else if STEPMODE=1, go to IDLE.
  - Else if RUN=1, go to ISSUE (back-to-back, 1 idle cycle minimum between start requests).
  - Else go to IDLE.
- Clearing RUN while in ISSUE or WAIT does not abort. The in-flight iteration completes, then the FSM goes to IDLE.
- HALT transitions:
  - Stay in HALT while RUN=1 or STEPMODE=1.
  - When both are 0, go to IDLE and clear oBreakHit.
- Step pending:
  - An iStepAABB pulse in ISSUE, WAIT or HALT with STEPMODE=1 sets stepPending (depth 1).
  - Further pulses while stepPending is set are dropped.
  - The pending step is consumed in IDLE.
  - Pulses with STEPMODE=0 are ignored.
- Counter:
  - Saturates at 2^CNT_W-1. No wrap.
  - CLR_BIT=1 clears it synchronously in any state, and clear wins over a simultaneous increment.
  - Breakpoint compare uses the pre-saturation value (count+1).
  - iBreakpoint=0 never matches once the counter is nonzero.
- iAABBDone in IDLE, ISSUE (without ack) or HALT is ignored and not counted.
- Latency:
  - Step pulse to oAABBStart: 1 cycle.
  - Done to oIterCount update: 1 cycle.

Optional Feature:
- Macro: AABB_STEP_TIMEOUT_EN.
- Defined:
  - A watchdog counter of width clog2(TIMEOUT_CYCLES+1) resets on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without iAABBDone, go to HALT and set oTimeout (sticky). oTimeout clears on the same HALT exit rule as oBreakHit.
  - If done arrives in the same cycle as the limit, done wins.
- Undefined: no watchdog logic, oTimeout tied to 0, WAIT waits indefinitely.

Test Plan:
- Reset and step: iReset=0 then 1; STEPMODE=1, pulse iStepAABB → oAABBStart=1 next cycle. Ack after 3 cycles, done 5 cycles later → oIterCount=1, FSM in IDLE, no second start.
- Free run: RUN=1, STEPMODE=0, AABB model acks in 1 cycle and finishes in 4 → starts repeat; after 10 dones oIterCount=10. Clear RUN mid-WAIT → current done counted (11), then IDLE.
- Breakpoint halt: BRK_EN=1, iBreakpoint=5, RUN=1 → halt after 5th done with oHalted=1, oBreakHit=1, oIterCount=5. Clear RUN → IDLE, oBreakHit=0.
- Pending and edge cases:
  - Two step pulses during one WAIT in step mode → exactly one extra iteration (count 2), second pulse dropped.
  - Ack and done in the same cycle → count increments once.
  - CLR together with done → count=0.
- Saturation and reset: CNT_W=4, free run 20 iterations → oIterCount stays 15. Assert iReset=0 during ISSUE → oAABBStart falls immediately and asynchronously; all outputs 0.
- Timeout (with AABB_STEP_TIMEOUT_EN, TIMEOUT_CYCLES=8): ack given, done withheld → HALT with oTimeout=1 after 8 WAIT cycles. Repeat with done exactly on cycle 8 → no timeout.
